// File: rtl/snowbro2_snd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snowbro2_snd_pkg : FSM encodings and byte-lane helpers, PCM fetch  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package snowbro2_snd_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;
   localparam logic [1:0] ST_PREF = 2'd3;

   localparam int PCM_BANK_BIT = 18;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   // Even byte addresses live in the low half of the SDRAM word.
   function automatic logic [7:0] pcm_lane(input logic [15:0] word, input logic lane);
      return (lane == LANE_LO) ? word[7:0] : word[15:8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/snowbro2_pcm_tagram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snowbro2_pcm_tagram : LINES x {valid, tag, word} line store        |
// | Second lookup port present with PCM_FETCH_PREFETCH_EN. Rev 1.0     |
// +--------------------------------------------------------------------+
module snowbro2_pcm_tagram #(
   parameter int LINES = 8,
   parameter int TW    = 15
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     we_i,
   input  logic [$clog2(LINES)-1:0] widx_i,
   input  logic [TW-1:0]            wtag_i,
   input  logic [15:0]              wdata_i,
   input  logic [$clog2(LINES)-1:0] ridx_i,
   output logic                     rvalid_o,
   output logic [TW-1:0]            rtag_o,
   output logic [15:0]              rdata_o
`ifdef PCM_FETCH_PREFETCH_EN
   ,
   input  logic [$clog2(LINES)-1:0] pidx_i,
   output logic                     pvalid_o,
   output logic [TW-1:0]            ptag_o
`endif
);

   logic [LINES-1:0] valid_q;
   logic [TW-1:0]    tag_q  [LINES];
   logic [15:0]      data_q [LINES];

   // Clear-all outranks a same-cycle write so a bank change never leaves a live line.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else if (clr_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[widx_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i && !clr_i) begin
         tag_q[widx_i]  <= wtag_i;
         data_q[widx_i] <= wdata_i;
      end
   end

   assign rvalid_o = valid_q[ridx_i];
   assign rtag_o   = tag_q[ridx_i];
   assign rdata_o  = data_q[ridx_i];

`ifdef PCM_FETCH_PREFETCH_EN
   assign pvalid_o = valid_q[pidx_i];
   assign ptag_o   = tag_q[pidx_i];
`endif

endmodule
`default_nettype wire

// File: rtl/snowbro2_pcm_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | snowbro2_pcm_fetch : jt6295 byte port -> 16-bit SDRAM line buffer  |
// | Optional next-line prefetch: PCM_FETCH_PREFETCH_EN. Rev 1.0        |
// +--------------------------------------------------------------------+
module snowbro2_pcm_fetch
   import snowbro2_snd_pkg::*;
#(
   parameter int LINES = 8,
   parameter int AW    = 19
) (
   input  logic          CLK96,
   input  logic          RESET96_N,
   input  logic [17:0]   OKI_ADDR,
   input  logic          OKI_BANK,
   output logic [7:0]    OKI_DATA,
   output logic          OKI_OK,
   output logic          ROM_CS,
   output logic [AW-1:0] ROM_ADDR,
   input  logic [15:0]   ROM_DATA,
   input  logic          ROM_OK
);

   localparam int IW = $clog2(LINES);
   localparam int TW = 18 - IW;

   logic [1:0]    state_q, state_d;
   logic [17:0]   line_q, line_d;     // {bank, word address}
   logic          first_q, first_d;
   logic          kill_q, kill_d;
   logic [15:0]   data_q, data_d;
   logic          bank_q;
   logic          clr_q;

   logic [17:0]   dem_line;
   logic          rd_valid;
   logic [TW-1:0] rd_tag;
   logic [15:0]   rd_data;
   logic          hit;
   logic          flip;
   logic          we;

   assign dem_line = {OKI_BANK, OKI_ADDR[17:1]};
   assign hit      = rd_valid && (rd_tag == dem_line[17:IW]);
   assign flip     = OKI_BANK ^ bank_q;

`ifdef PCM_FETCH_PREFETCH_EN
   logic          pref_q, pref_d;
   logic [17:0]   pref_line;
   logic          p_valid;
   logic [TW-1:0] p_tag;
   logic          pref_hit;

   // Next line stays in the same bank and wraps within it.
   assign pref_line = {line_q[17], line_q[16:0] + 17'd1};
   assign pref_hit  = p_valid && (p_tag == pref_line[17:IW]);
`endif

   snowbro2_pcm_tagram #(
      .LINES (LINES),
      .TW    (TW)
   ) u_tagram (
      .clk_i    (CLK96),
      .rst_ni   (RESET96_N),
      .clr_i    (clr_q),
      .we_i     (we),
      .widx_i   (line_q[IW-1:0]),
      .wtag_i   (line_q[17:IW]),
      .wdata_i  (data_q),
      .ridx_i   (dem_line[IW-1:0]),
      .rvalid_o (rd_valid),
      .rtag_o   (rd_tag),
      .rdata_o  (rd_data)
`ifdef PCM_FETCH_PREFETCH_EN
      ,
      .pidx_i   (pref_line[IW-1:0]),
      .pvalid_o (p_valid),
      .ptag_o   (p_tag)
`endif
   );

   always_comb begin
      state_d = state_q;
      line_d  = line_q;
      first_d = 1'b0;
      kill_d  = kill_q;
      data_d  = data_q;
      we      = 1'b0;
`ifdef PCM_FETCH_PREFETCH_EN
      pref_d  = pref_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!hit) begin
               state_d = ST_REQ;
               line_d  = dem_line;
               first_d = 1'b1;
`ifdef PCM_FETCH_PREFETCH_EN
               pref_d  = 1'b0;
`endif
            end
         end
         ST_REQ: begin
            // A bank change lets the bus cycle finish but discards its data.
            if (flip) kill_d = 1'b1;
            if (!first_q && ROM_OK) begin
               state_d = ST_FILL;
               data_d  = ROM_DATA;
            end
         end
         ST_FILL: begin
            we      = !kill_q && !flip;
            kill_d  = 1'b0;
            state_d = ST_IDLE;
`ifdef PCM_FETCH_PREFETCH_EN
            if (we && !pref_q) state_d = ST_PREF;
`endif
         end
`ifdef PCM_FETCH_PREFETCH_EN
         ST_PREF: begin
            if (flip || clr_q) begin
               state_d = ST_IDLE;
            end else if (!hit) begin
               state_d = ST_REQ;
               line_d  = dem_line;
               first_d = 1'b1;
               pref_d  = 1'b0;
            end else if (!pref_hit) begin
               state_d = ST_REQ;
               line_d  = pref_line;
               first_d = 1'b1;
               pref_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         state_q <= ST_IDLE;
         line_q  <= '0;
         first_q <= 1'b0;
         kill_q  <= 1'b0;
         data_q  <= '0;
         bank_q  <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
         first_q <= first_d;
         kill_q  <= kill_d;
         data_q  <= data_d;
         bank_q  <= OKI_BANK;
         clr_q   <= flip;
      end
   end

`ifdef PCM_FETCH_PREFETCH_EN
   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         pref_q <= 1'b0;
      end else begin
         pref_q <= pref_d;
      end
   end
`endif

   assign ROM_CS   = (state_q == ST_REQ);
   assign OKI_OK   = hit;
   assign OKI_DATA = hit ? pcm_lane(rd_data, OKI_ADDR[0]) : 8'h00;

   always_comb begin
      ROM_ADDR               = '0;
      ROM_ADDR[PCM_BANK_BIT] = line_q[17];
      ROM_ADDR[16:0]         = line_q[16:0];
   end

endmodule
`default_nettype wire

// File: tb/tb_snowbro2_pcm_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_snowbro2_pcm_fetch : directed bench for snowbro2_pcm_fetch      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_snowbro2_pcm_fetch;

   logic        CLK96     = 1'b0;
   logic        RESET96_N = 1'b0;
   logic [17:0] OKI_ADDR  = '0;
   logic        OKI_BANK  = 1'b0;
   logic [7:0]  OKI_DATA;
   logic        OKI_OK;
   logic        ROM_CS;
   logic [18:0] ROM_ADDR;
   logic [15:0] ROM_DATA  = '0;
   logic        ROM_OK    = 1'b0;

   int          tests = 0;
   int          fails = 0;
   logic        seen;
   logic [18:0] got_addr;

   always #5 CLK96 = ~CLK96;

   snowbro2_pcm_fetch #(
      .LINES (8),
      .AW    (19)
   ) dut (
      .CLK96     (CLK96),
      .RESET96_N (RESET96_N),
      .OKI_ADDR  (OKI_ADDR),
      .OKI_BANK  (OKI_BANK),
      .OKI_DATA  (OKI_DATA),
      .OKI_OK    (OKI_OK),
      .ROM_CS    (ROM_CS),
      .ROM_ADDR  (ROM_ADDR),
      .ROM_DATA  (ROM_DATA),
      .ROM_OK    (ROM_OK)
   );

   task automatic step;
      @(posedge CLK96);
      #1;
   endtask

   // SDRAM model: wait for ROM_CS, then answer lat cycles after it rose.
   task automatic serve(input logic [15:0] d, input int lat,
                        output logic found, output logic [18:0] a);
      found = 1'b0;
      a     = '0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge CLK96);
         if (ROM_CS) begin
            found = 1'b1;
            a     = ROM_ADDR;
         end
      end
      if (found) begin
         repeat (lat) @(posedge CLK96);
         #1;
         ROM_OK   = 1'b1;
         ROM_DATA = d;
         step();
         ROM_OK   = 1'b0;
      end
   endtask

   task automatic test_reset;
      OKI_ADDR = 18'h00010;
      repeat (2) @(posedge CLK96);
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b0) begin fails++; $display("FAIL reset_rom_cs: got %b want 0", ROM_CS); end
      tests++; if (ROM_ADDR !== 19'h0) begin fails++; $display("FAIL reset_rom_addr: got %h want 0", ROM_ADDR); end
      tests++; if (OKI_OK !== 1'b0) begin fails++; $display("FAIL reset_oki_ok: got %b want 0", OKI_OK); end
      tests++; if (OKI_DATA !== 8'h00) begin fails++; $display("FAIL reset_oki_data: got %h want 00", OKI_DATA); end
      step();
      RESET96_N = 1'b1;
   endtask

   task automatic test_basic;
      int n;
      serve(16'hBEEF, 3, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00008) begin fails++; $display("FAIL basic_req: seen %b addr %h want 00008", seen, got_addr); end
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b0) begin fails++; $display("FAIL basic_fill_ok: got %b want 0", OKI_OK); end
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'hEF) begin fails++; $display("FAIL basic_hit_lo: ok %b data %h want 1 EF", OKI_OK, OKI_DATA); end
      step();
      OKI_ADDR = 18'h00011;
      #1;
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'hBE) begin fails++; $display("FAIL basic_hit_hi: ok %b data %h want 1 BE", OKI_OK, OKI_DATA); end
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK96);
         if (ROM_CS) n++;
      end
      tests++; if (n != 0) begin fails++; $display("FAIL basic_no_req: got %0d cs cycles want 0", n); end
   endtask

   task automatic test_stale_ok;
      step();
      OKI_ADDR = 18'h00040;
      ROM_OK   = 1'b1;
      ROM_DATA = 16'hDEAD;
      step();
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b1) begin fails++; $display("FAIL stale_rise_cs: got %b want 1", ROM_CS); end
      step();
      ROM_OK = 1'b0;
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b1) begin fails++; $display("FAIL stale_ignored: cs %b want 1", ROM_CS); end
      step();
      step();
      ROM_OK   = 1'b1;
      ROM_DATA = 16'h1234;
      step();
      ROM_OK = 1'b0;
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b0 || ROM_CS !== 1'b0) begin fails++; $display("FAIL stale_fill: ok %b cs %b want 0 0", OKI_OK, ROM_CS); end
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'h34) begin fails++; $display("FAIL stale_data: ok %b data %h want 1 34", OKI_OK, OKI_DATA); end
   endtask

   task automatic test_bank_flip;
      step();
      OKI_ADDR = 18'h00020;
      @(negedge CLK96);
      step();
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b1 || ROM_ADDR !== 19'h00010) begin fails++; $display("FAIL flip_req0: cs %b addr %h want 1 00010", ROM_CS, ROM_ADDR); end
      step();
      OKI_BANK = 1'b1;
      step();
      ROM_OK   = 1'b1;
      ROM_DATA = 16'h1111;
      step();
      ROM_OK = 1'b0;
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b0 || OKI_OK !== 1'b0) begin fails++; $display("FAIL flip_fill: cs %b ok %b want 0 0", ROM_CS, OKI_OK); end
      serve(16'h5678, 2, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h40010) begin fails++; $display("FAIL flip_req1: seen %b addr %h want 40010", seen, got_addr); end
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'h78) begin fails++; $display("FAIL flip_data: ok %b data %h want 1 78", OKI_OK, OKI_DATA); end
   endtask

   task automatic test_conflict;
      step();
      OKI_BANK = 1'b0;
      OKI_ADDR = 18'h00000;
      serve(16'hA1B2, 1, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00000) begin fails++; $display("FAIL conf_req_a: seen %b addr %h want 00000", seen, got_addr); end
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'hB2) begin fails++; $display("FAIL conf_data_a: ok %b data %h want 1 B2", OKI_OK, OKI_DATA); end
      step();
      OKI_ADDR = 18'h00010;
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b0) begin fails++; $display("FAIL conf_miss_b: got %b want 0", OKI_OK); end
      serve(16'hC3D4, 1, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00008) begin fails++; $display("FAIL conf_req_b: seen %b addr %h want 00008", seen, got_addr); end
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'hD4) begin fails++; $display("FAIL conf_data_b: ok %b data %h want 1 D4", OKI_OK, OKI_DATA); end
      step();
      OKI_ADDR = 18'h00000;
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b0) begin fails++; $display("FAIL conf_miss_a: got %b want 0", OKI_OK); end
      serve(16'hA1B2, 1, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00000) begin fails++; $display("FAIL conf_rereq_a: seen %b addr %h want 00000", seen, got_addr); end
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'hB2) begin fails++; $display("FAIL conf_redata_a: ok %b data %h want 1 B2", OKI_OK, OKI_DATA); end
   endtask

   task automatic test_async_reset;
      step();
      OKI_ADDR = 18'h00030;
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b1 || ROM_ADDR !== 19'h00018) begin fails++; $display("FAIL arst_req: cs %b addr %h want 1 00018", ROM_CS, ROM_ADDR); end
      step();
      OKI_ADDR = 18'h00001;
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'hA1 || ROM_CS !== 1'b1) begin fails++; $display("FAIL arst_hit_in_req: ok %b data %h cs %b want 1 A1 1", OKI_OK, OKI_DATA, ROM_CS); end
      #1;
      RESET96_N = 1'b0;
      #1;
      tests++; if (ROM_CS !== 1'b0 || OKI_OK !== 1'b0) begin fails++; $display("FAIL arst_drop: cs %b ok %b want 0 0", ROM_CS, OKI_OK); end
      OKI_ADDR = 18'h00030;
      step();
      step();
      RESET96_N = 1'b1;
      serve(16'h9988, 2, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00018) begin fails++; $display("FAIL arst_rereq: seen %b addr %h want 00018", seen, got_addr); end
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'h88) begin fails++; $display("FAIL arst_data: ok %b data %h want 1 88", OKI_OK, OKI_DATA); end
   endtask

   task automatic test_prefetch;
      int n;
      step();
      OKI_ADDR = 18'h00100;
      serve(16'h0102, 2, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00080) begin fails++; $display("FAIL pref_req0: seen %b addr %h want 00080", seen, got_addr); end
      @(negedge CLK96);
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'h02) begin fails++; $display("FAIL pref_data0: ok %b data %h want 1 02", OKI_OK, OKI_DATA); end
`ifdef PCM_FETCH_PREFETCH_EN
      serve(16'h0304, 1, seen, got_addr);
      tests++; if (!seen || got_addr !== 19'h00081) begin fails++; $display("FAIL pref_req1: seen %b addr %h want 00081", seen, got_addr); end
      @(negedge CLK96);
      step();
      OKI_ADDR = 18'h00102;
      #1;
      tests++; if (OKI_OK !== 1'b1 || OKI_DATA !== 8'h04) begin fails++; $display("FAIL pref_hit: ok %b data %h want 1 04", OKI_OK, OKI_DATA); end
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK96);
         if (ROM_CS) n++;
      end
      tests++; if (n != 0) begin fails++; $display("FAIL pref_no_req: got %0d cs cycles want 0", n); end
`else
      n = 0;
      step();
      OKI_ADDR = 18'h00102;
      @(negedge CLK96);
      tests++; if (OKI_OK !== 1'b0) begin fails++; $display("FAIL nopref_miss: got %b want 0", OKI_OK); end
      @(negedge CLK96);
      tests++; if (ROM_CS !== 1'b1 || ROM_ADDR !== 19'h00081) begin fails++; $display("FAIL nopref_req: cs %b addr %h want 1 00081 (%0d)", ROM_CS, ROM_ADDR, n); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stale_ok();
      test_bank_flip();
      test_conflict();
      test_async_reset();
      test_prefetch();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
